seg7_reg_scan: RTL

Register-file display driver downstream of the CPU top's register debug port. Drives `reg_sel` into the top, takes a per-frame snapshot of the returned `reg_data`, and time-multiplexes the 32-bit value as 8 hex digits on a common-anode 7-segment bank. The register is selected either from board switches or by an auto-stepping sweep through r0..r31.

---
 rtl/seg7_reg_scan.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seg7_reg_scan.sv
`default_nettype none
// ============================================================================
// Module  : seg7_reg_scan
// Brief   : Register-debug display driver; multiplexes a per-frame snapshot of
//           reg_data as 8 hex digits. Optional macro SEG_BLANK_LZ_EN blanks
//           leading zeros.
// Revision: 1.0
// ============================================================================
module seg7_reg_scan #(
  parameter int SCAN_DIV    = 100000,
  parameter int STEP_FRAMES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sw_sel,
  input  logic        auto_en,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(STEP_FRAMES - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [4:0]    sel_q, sel_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          ft_q, ft_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    nibble;
  logic [2:0]    top_nz;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Index of the highest nonzero nibble; 0 when the snapshot is all zero.
  always_comb begin
    top_nz = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (shadow_q[4*i +: 4] != 4'h0) top_nz = 3'(i);
    end
  end

  always_comb begin
    tick     = (pcnt_q == PCNT_LAST);
    boundary = tick && (dig_q == 3'd7);
    pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
    dig_d    = tick ? dig_q + 3'd1 : dig_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    fcnt_d   = fcnt_q;

    // Snapshot still belongs to the old reg_sel, which was held all frame.
    if (boundary) begin
      shadow_d = reg_data;
      if (!auto_en) begin
        sel_d  = sw_sel;
        fcnt_d = '0;
      end else if (fcnt_q == FCNT_LAST) begin
        fcnt_d = '0;
        sel_d  = sel_q + 5'd1;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    nibble = shadow_q[{dig_q, 2'b00} +: 4];
    an_d   = ~(8'd1 << dig_q);
    seg_d  = {~(auto_en && (dig_q == 3'd0)), hex7(nibble)};
`ifdef SEG_BLANK_LZ_EN
    if (dig_q > top_nz) seg_d[6:0] = 7'h7F;
`endif
    ft_d   = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      dig_q    <= 3'd0;
      fcnt_q   <= '0;
      shadow_q <= 32'd0;
      sel_q    <= 5'd0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
      ft_q     <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      dig_q    <= dig_d;
      fcnt_q   <= fcnt_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      ft_q     <= ft_d;
    end
  end

  assign reg_sel    = sel_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = ft_q;

`ifndef SEG_BLANK_LZ_EN
  logic unused_ok;
  assign unused_ok = ^top_nz;
`endif

endmodule
`default_nettype wire
